// File: rtl/calc_pkg.sv
// Calculator command codes, keypad map and FSM state types
// shared by the keypad command encoder and its FIFO.
package calc_pkg;

   localparam logic [3:0] CMD_ADD  = 4'b1010;
   localparam logic [3:0] CMD_SUB  = 4'b1011;
   localparam logic [3:0] CMD_MUL  = 4'b1100;
   localparam logic [3:0] CMD_NOP  = 4'b1101;
   localparam logic [3:0] CMD_EQ   = 4'b1110;
   localparam logic [3:0] CMD_BKSP = 4'b1111;

   // Indexed by {row, col}; bit 4 marks a mapped key.
   localparam logic [15:0][4:0] KEY_MAP = {
      5'b0_0000,           {1'b1, CMD_EQ},   5'b1_0000, {1'b1, CMD_BKSP},
      {1'b1, CMD_MUL},     5'b1_1001,        5'b1_1000, 5'b1_0111,
      {1'b1, CMD_SUB},     5'b1_0110,        5'b1_0101, 5'b1_0100,
      {1'b1, CMD_ADD},     5'b1_0011,        5'b1_0010, 5'b1_0001
   };

   typedef enum logic [1:0] {
      S_SCAN,
      S_DEBOUNCE,
      S_HELD,
      S_RELEASE
   } scan_st_t;

   typedef enum logic [1:0] {
      E_IDLE,
      E_HOLD,
      E_GAP
   } emit_st_t;

   function automatic logic [1:0] lowest_col(input logic [3:0] c_n);
      if (!c_n[0])      return 2'd0;
      else if (!c_n[1]) return 2'd1;
      else if (!c_n[2]) return 2'd2;
      else              return 2'd3;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// 4-entry x 4-bit command FIFO; a push on a full FIFO
// succeeds only when a pop happens in the same cycle.
module cmd_fifo
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_push,
   input  logic [3:0] i_data,
   input  logic       i_pop,
   output logic [3:0] o_data,
   output logic       o_full,
   output logic       o_empty
);

   logic [3:0] r_mem [4];
   logic [1:0] r_wp;
   logic [1:0] r_rp;
   logic [2:0] r_cnt;
   logic       w_do_pop;
   logic       w_do_push;

   assign o_full    = (r_cnt == 3'd4);
   assign o_empty   = (r_cnt == 3'd0);
   assign o_data    = r_mem[r_rp];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wp] <= i_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wp  <= 2'd0;
         r_rp  <= 2'd0;
         r_cnt <= 3'd0;
      end else begin
         if (w_do_push) r_wp <= r_wp + 2'd1;
         if (w_do_pop)  r_rp <= r_rp + 2'd1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + 3'd1;
            2'b01:   r_cnt <= r_cnt - 3'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/keypad_cmd_encoder.sv
// 4x4 keypad scanner + command emitter. Define KEYPAD_CMD_FIFO_EN
// to queue keys arriving while busy instead of dropping them.
module keypad_cmd_encoder
   import calc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SCAN_DWELL      = 2,
   parameter int HOLD_CYCLES     = 10,
   parameter int GAP_CYCLES      = 2
)
(
   input  logic       clock,
   input  logic       reset,
   output logic [3:0] rows,
   input  logic [3:0] cols,
   output logic [3:0] cmd,
   output logic       cmd_valid,
   output logic       busy,
   output logic       dropped
);

   localparam logic [15:0] DWELL_LAST =
      16'((SCAN_DWELL > 1) ? SCAN_DWELL - 1 : 0);
   localparam logic [15:0] DEB_LAST =
      16'((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0);
   localparam logic [15:0] HOLD_LAST =
      16'((HOLD_CYCLES > 1) ? HOLD_CYCLES - 1 : 0);
   localparam logic [15:0] GAP_LAST =
      16'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);

   scan_st_t    r_sst, w_sst_nxt;
   logic [1:0]  r_row, w_row_nxt;
   logic [1:0]  r_col, w_col_nxt;
   logic [15:0] r_scnt, w_scnt_nxt;
   logic        w_any_low;
   logic        w_col_low;
   logic        w_accept;
   logic        w_event;
   logic [4:0]  w_key;

   emit_st_t    r_est, w_est_nxt;
   logic [15:0] r_ecnt, w_ecnt_nxt;
   logic [3:0]  r_code, w_code_nxt;
   logic        w_take;
   logic [3:0]  w_take_code;
   logic        w_pending;

   assign rows      = ~(4'b0001 << r_row);
   assign w_any_low = ~&cols;
   assign w_col_low = ~cols[r_col];
   assign w_key     = KEY_MAP[{r_row, r_col}];
   assign w_event   = w_accept && w_key[4];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sst  <= S_SCAN;
         r_row  <= 2'd0;
         r_col  <= 2'd0;
         r_scnt <= 16'd0;
      end else begin
         r_sst  <= w_sst_nxt;
         r_row  <= w_row_nxt;
         r_col  <= w_col_nxt;
         r_scnt <= w_scnt_nxt;
      end
   end

   always_comb begin
      w_sst_nxt  = r_sst;
      w_row_nxt  = r_row;
      w_col_nxt  = r_col;
      w_scnt_nxt = r_scnt;
      w_accept   = 1'b0;
      case (r_sst)
         S_SCAN: begin
            if (r_scnt == DWELL_LAST) begin
               w_scnt_nxt = 16'd0;
               if (w_any_low) begin
                  w_sst_nxt = S_DEBOUNCE;
                  w_col_nxt = lowest_col(cols);
               end else begin
                  w_row_nxt = r_row + 2'd1;
               end
            end else begin
               w_scnt_nxt = r_scnt + 16'd1;
            end
         end
         S_DEBOUNCE: begin
            if (!w_col_low) begin
               w_sst_nxt  = S_SCAN;
               w_scnt_nxt = 16'd0;
            end else if (r_scnt == DEB_LAST) begin
               w_accept   = 1'b1;
               w_sst_nxt  = S_HELD;
               w_scnt_nxt = 16'd0;
            end else begin
               w_scnt_nxt = r_scnt + 16'd1;
            end
         end
         S_HELD: begin
            if (!w_col_low) begin
               w_sst_nxt  = S_RELEASE;
               w_scnt_nxt = 16'd0;
            end
         end
         S_RELEASE: begin
            if (w_col_low) begin
               w_sst_nxt  = S_HELD;
               w_scnt_nxt = 16'd0;
            end else if (r_scnt == DEB_LAST) begin
               w_sst_nxt  = S_SCAN;
               w_row_nxt  = r_row + 2'd1;
               w_scnt_nxt = 16'd0;
            end else begin
               w_scnt_nxt = r_scnt + 16'd1;
            end
         end
         default: w_sst_nxt = S_SCAN;
      endcase
   end

`ifdef KEYPAD_CMD_FIFO_EN
   logic       w_push;
   logic       w_pop;
   logic       w_full;
   logic       w_empty;
   logic [3:0] w_head;

   // An idle emitter with nothing queued takes the key directly.
   assign w_pop       = (r_est == E_IDLE) && !w_empty;
   assign w_push      = w_event && !((r_est == E_IDLE) && w_empty);
   assign w_take      = (r_est == E_IDLE) && (w_event || !w_empty);
   assign w_take_code = w_empty ? w_key[3:0] : w_head;
   assign w_pending   = !w_empty;
   assign dropped     = w_push && w_full && !w_pop;

   cmd_fifo u_fifo (
      .i_clk   (clock),
      .i_rst_n (reset),
      .i_push  (w_push),
      .i_data  (w_key[3:0]),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );
`else
   assign w_take      = (r_est == E_IDLE) && w_event;
   assign w_take_code = w_key[3:0];
   assign w_pending   = 1'b0;
   assign dropped     = w_event && (r_est != E_IDLE);
`endif

   assign busy = (r_est != E_IDLE) || w_pending;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_est  <= E_IDLE;
         r_ecnt <= 16'd0;
         r_code <= CMD_NOP;
      end else begin
         r_est  <= w_est_nxt;
         r_ecnt <= w_ecnt_nxt;
         r_code <= w_code_nxt;
      end
   end

   always_comb begin
      w_est_nxt  = r_est;
      w_ecnt_nxt = r_ecnt;
      w_code_nxt = r_code;
      cmd        = CMD_NOP;
      cmd_valid  = 1'b0;
      case (r_est)
         E_IDLE: begin
            if (w_take) begin
               w_est_nxt  = E_HOLD;
               w_ecnt_nxt = 16'd0;
               w_code_nxt = w_take_code;
            end
         end
         E_HOLD: begin
            cmd       = r_code;
            cmd_valid = 1'b1;
            if (r_ecnt == HOLD_LAST) begin
               w_ecnt_nxt = 16'd0;
               w_est_nxt  = (GAP_CYCLES == 0) ? E_IDLE : E_GAP;
            end else begin
               w_ecnt_nxt = r_ecnt + 16'd1;
            end
         end
         E_GAP: begin
            if (r_ecnt == GAP_LAST) begin
               w_ecnt_nxt = 16'd0;
               w_est_nxt  = E_IDLE;
            end else begin
               w_ecnt_nxt = r_ecnt + 16'd1;
            end
         end
         default: w_est_nxt = E_IDLE;
      endcase
   end

endmodule

// File: doc/keypad_cmd_encoder.md
KEYPAD_CMD_ENCODER -- requirements
Module: keypad_cmd_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive identical samples required to accept a press or release.
REQ-002 SHALL have parameter SCAN_DWELL, default 2, meaning cycles each row is driven before its columns are sampled.
REQ-003 SHALL have parameter HOLD_CYCLES, default 10, meaning cycles each command code is held on cmd.
REQ-004 SHALL have parameter GAP_CYCLES, default 2, meaning NOP cycles inserted after each held command.
REQ-005 SHALL have port clock, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port rows, output, 4 bits: keypad row drive, active-low, one-hot.
REQ-008 SHALL have port cols, input, 4 bits: keypad column sense, active-low, synchronous to clock.
REQ-009 SHALL have port cmd, output, 4 bits: calculator command code.
REQ-010 SHALL have port cmd_valid, output, 1 bit: high while cmd carries a real command.
REQ-011 SHALL have port busy, output, 1 bit: emitter not idle, or pending commands queued.
REQ-012 SHALL have port dropped, output, 1 bit: one-cycle pulse when an accepted key is discarded.

Function
REQ-013 SHALL use these codes: digits 0-9 = 4'd0-4'd9; ADD 1010; SUB 1011; MUL 1100; NOP 1101; EQ 1110; BKSP 1111.
REQ-014 SHALL use this key map, row r and col c: r0 = 1,2,3,ADD; r1 = 4,5,6,SUB; r2 = 7,8,9,MUL; r3 = BKSP,0,EQ,unmapped.
REQ-015 SHALL ignore the unmapped key (r3,c3) entirely: no command, no dropped pulse.
REQ-016 Scanner FSM states SHALL be SCAN, DEBOUNCE, HELD, and RELEASE.
- SCAN: drive row r low for SCAN_DWELL cycles, then sample cols.
- If no column is low, advance r modulo 4 (3 wraps to 0).
REQ-017 If more than one column is low, the lowest column index SHALL win.
REQ-018 A low column in SCAN SHALL move the FSM to DEBOUNCE, parked on that row.
- DEBOUNCE samples every cycle.
- DEBOUNCE_CYCLES consecutive low samples of the same column accept the key and move to HELD.
- Any mismatching sample returns to SCAN on the same row.
REQ-019 On acceptance, the FSM SHALL issue exactly one key event in the cycle of the final matching sample; auto-repeat SHALL NOT occur.
REQ-020 HELD SHALL stay parked until the column reads high, then move to RELEASE.
- RELEASE requires DEBOUNCE_CYCLES consecutive high samples, then goes to SCAN on the next row.
- A low sample in RELEASE returns to HELD.
REQ-021 Emitter FSM states SHALL be IDLE, HOLD, and GAP.
- IDLE to HOLD: on a key event, or when a queued entry exists.
- HOLD: cmd = code and cmd_valid = 1 for exactly HOLD_CYCLES cycles.
- GAP: cmd = NOP and cmd_valid = 0 for exactly GAP_CYCLES cycles, then IDLE.
REQ-022 A key event in IDLE SHALL drive cmd in the following cycle (latency 1).
REQ-023 SHALL drive cmd = NOP and cmd_valid = 0 whenever the emitter is in IDLE.
REQ-024 busy SHALL be high whenever the emitter is in HOLD or GAP, or the queue is non-empty.

Reset
REQ-025 Asserting reset SHALL immediately set: rows = 1110, cmd = 1101, cmd_valid = 0, busy = 0, dropped = 0, scanner = SCAN on row 0, emitter = IDLE, queue empty.
REQ-026 Reset asserted mid-HOLD SHALL abort the command with no further output, and SHALL NOT replay it after release.

Configuration
REQ-027 Macro KEYPAD_CMD_FIFO_EN defined: SHALL instantiate a 4-entry FIFO between scanner and emitter.
- An event arriving when the FIFO is full SHALL pulse dropped and be discarded.
- A push and a pop in the same cycle on a full FIFO SHALL succeed without a drop.
- Emission SHALL follow arrival order.
REQ-028 Macro KEYPAD_CMD_FIFO_EN undefined: SHALL have no FIFO; a key event while the emitter is in HOLD or GAP SHALL pulse dropped and be discarded.

Structure
REQ-029 Package calc_pkg SHALL hold the command code constants (CMD_ADD, CMD_SUB, CMD_MUL, CMD_EQ, CMD_BKSP, CMD_NOP) and the 16-entry key-map table.
REQ-030 Sub-module cmd_fifo (4 x 4-bit, full/empty flags) SHALL exist and be instantiated only under KEYPAD_CMD_FIFO_EN; scanner and emitter SHALL stay in keypad_cmd_encoder.

Verification
REQ-031 Hold cols = 1011 while rows = 1101 for 12 cycles -> cmd = 0110 with cmd_valid = 1 for 10 cycles, then NOP for 2 cycles, then IDLE.
REQ-032 Cols bounce low/high/low in DEBOUNCE -> no command; a stable press afterwards -> exactly one command.
REQ-033 Keys 6, MUL, 2, EQ pressed and released in sequence -> cmd sequence 0110, 1100, 0010, 1110, each held 10 cycles and separated by NOP.
REQ-034 Second key accepted during HOLD -> with the macro: emitted after GAP; without the macro: dropped = 1 for one cycle and only the first key is emitted.
REQ-035 Press (r3,c3) -> cmd stays NOP and dropped stays 0; a key held for 100 cycles -> exactly one command.
REQ-036 reset = 0 mid-HOLD -> cmd = 1101 and cmd_valid = 0 immediately, and no replay after release.
